// File: rtl/ptp_ts_collect_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ptp_ts_collect_fifo
//  Purpose  : Small synchronous FIFO that buffers one port's timestamp+tag
//             records. The read side is first-word-fall-through: rd_data
//             always shows the head entry, and rd_en pops it.
//  Ports    : clk, rst (async active-high)
//             wr_en / wr_data       push side (ignored while full)
//             rd_en / rd_data       pop side (ignored while empty)
//             full / empty          status flags from registered pointers
//  Revision : 1.0  initial release
// ============================================================================
module ptp_ts_collect_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  // One extra pointer bit tells a full FIFO apart from an empty one.
  localparam int ADDR_WIDTH = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  do_write;
  logic                  do_read;

  assign full  = (wr_ptr_q[ADDR_WIDTH-1] != rd_ptr_q[ADDR_WIDTH-1]) &&
                 (wr_ptr_q[ADDR_WIDTH-2:0] == rd_ptr_q[ADDR_WIDTH-2:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  assign rd_data = mem[rd_ptr_q[ADDR_WIDTH-2:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(do_write);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(do_read);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q[ADDR_WIDTH-2:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ptp_ts_collect.sv
`default_nettype none
// ============================================================================
//  Module   : ptp_ts_collect
//  Purpose  : Collects PTP timestamp+tag records from PORTS MAC instances,
//             buffers each port in its own FIFO and merges them round-robin
//             into a single AXI-stream tagged with the source port index.
//             Sources cannot stall, so a record arriving at a full FIFO is
//             dropped, pulses overflow[i] and bumps a saturating counter.
//  Ports    : clk, rst                 clock, async active-high reset
//             s_axis_ptp_ts[_tag]      per-port packed inputs, port i at [i*W +: W]
//             s_axis_ptp_ts_valid      per-port valid (no ready)
//             m_axis_ptp_ts[_tag/_port/_valid], m_axis_ptp_ts_ready  merged stream
//             drop_count               per-port saturating drop counters
//             overflow                 per-port one-cycle drop pulse
//  Revision : 1.0  initial release
// ============================================================================
module ptp_ts_collect #(
  parameter int PORTS            = 4,
  parameter int PTP_TS_WIDTH     = 96,
  parameter int PTP_TAG_WIDTH    = 16,
  parameter int FIFO_DEPTH       = 16,
  parameter int DROP_COUNT_WIDTH = 16,
  localparam int PORT_WIDTH      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS*PTP_TS_WIDTH-1:0]       s_axis_ptp_ts,
  input  logic [PORTS*PTP_TAG_WIDTH-1:0]      s_axis_ptp_ts_tag,
  input  logic [PORTS-1:0]                    s_axis_ptp_ts_valid,
  output logic [PTP_TS_WIDTH-1:0]             m_axis_ptp_ts,
  output logic [PTP_TAG_WIDTH-1:0]            m_axis_ptp_ts_tag,
  output logic [PORT_WIDTH-1:0]               m_axis_ptp_ts_port,
  output logic                                m_axis_ptp_ts_valid,
  input  logic                                m_axis_ptp_ts_ready,
  output logic [PORTS*DROP_COUNT_WIDTH-1:0]   drop_count,
  output logic [PORTS-1:0]                    overflow
);

  localparam int DATA_WIDTH = PTP_TS_WIDTH + PTP_TAG_WIDTH;
  // Scan index is one bit wider so rr_ptr + k never overflows before wrapping.
  localparam int SCAN_WIDTH = PORT_WIDTH + 1;

  logic [PORTS-1:0]                  fifo_full;
  logic [PORTS-1:0]                  fifo_empty;
  logic [PORTS-1:0]                  fifo_wr_en;
  logic [PORTS-1:0]                  fifo_rd_en;
  logic [DATA_WIDTH-1:0]             fifo_rd_data [PORTS];

  logic                              load;
  logic                              grant_found;
  logic [PORT_WIDTH-1:0]             grant;
  logic [SCAN_WIDTH-1:0]             scan_idx;

  logic [PORT_WIDTH-1:0]             rr_ptr_q, rr_ptr_d;
  logic                              m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]             m_data_q, m_data_d;
  logic [PORT_WIDTH-1:0]             m_port_q, m_port_d;
  logic [PORTS*DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic [PORTS-1:0]                  overflow_q, overflow_d;

  // Full is taken from the registered pointers, so a pop in the same cycle
  // never rescues a write into a full FIFO.
  assign fifo_wr_en = s_axis_ptp_ts_valid & ~fifo_full;

  generate
    for (genvar i = 0; i < PORTS; i++) begin : g_port
      ptp_ts_collect_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_en[i]),
        .wr_data ({s_axis_ptp_ts[i*PTP_TS_WIDTH +: PTP_TS_WIDTH],
                   s_axis_ptp_ts_tag[i*PTP_TAG_WIDTH +: PTP_TAG_WIDTH]}),
        .rd_en   (fifo_rd_en[i]),
        .rd_data (fifo_rd_data[i]),
        .full    (fifo_full[i]),
        .empty   (fifo_empty[i])
      );
    end
  endgenerate

  // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan_idx    = '0;
    for (int k = 0; k < PORTS; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SCAN_WIDTH'(k);
      if (scan_idx >= SCAN_WIDTH'(PORTS)) begin
        scan_idx = scan_idx - SCAN_WIDTH'(PORTS);
      end
      if (!grant_found && !fifo_empty[scan_idx[PORT_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant       = scan_idx[PORT_WIDTH-1:0];
      end
    end
  end

  // Single-stage output register; it only refills when empty or accepted.
  assign load = !m_valid_q || m_axis_ptp_ts_ready;

  always_comb begin
    fifo_rd_en = '0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_port_d   = m_port_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      m_valid_d = grant_found;
      if (grant_found) begin
        fifo_rd_en[grant] = 1'b1;
        m_data_d          = fifo_rd_data[grant];
        m_port_d          = grant;
        rr_ptr_d          = (grant == PORT_WIDTH'(PORTS - 1)) ? '0
                                                              : grant + PORT_WIDTH'(1);
      end
    end
  end

  // Drop accounting: every port counts independently, saturating at all-ones.
  always_comb begin
    overflow_d   = s_axis_ptp_ts_valid & fifo_full;
    drop_count_d = drop_count_q;
    for (int i = 0; i < PORTS; i++) begin
      if (overflow_d[i] &&
          (drop_count_q[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] != {DROP_COUNT_WIDTH{1'b1}})) begin
        drop_count_d[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] =
          drop_count_q[i*DROP_COUNT_WIDTH +: DROP_COUNT_WIDTH] + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_port_q     <= '0;
      drop_count_q <= '0;
      overflow_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_port_q     <= m_port_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign m_axis_ptp_ts       = m_data_q[DATA_WIDTH-1 -: PTP_TS_WIDTH];
  assign m_axis_ptp_ts_tag   = m_data_q[PTP_TAG_WIDTH-1:0];
  assign m_axis_ptp_ts_port  = m_port_q;
  assign m_axis_ptp_ts_valid = m_valid_q;
  assign drop_count          = drop_count_q;
  assign overflow            = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ptp_ts_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ptp_ts_collect
//  Purpose  : Self-checking bench for ptp_ts_collect. A queue-based model of
//             per-port buffering, round-robin merge and drop accounting is
//             compared against the DUT every cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ptp_ts_collect;

  localparam int PORTS = 4;
  localparam int TSW   = 96;
  localparam int TAGW  = 16;
  localparam int DEPTH = 16;
  localparam int DCW   = 4;
  localparam int PW    = 2;
  localparam int DW    = TSW + TAGW;
  localparam int DMAX  = (1 << DCW) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PORTS*TSW-1:0]  s_ts = '0;
  logic [PORTS*TAGW-1:0] s_tag = '0;
  logic [PORTS-1:0]      s_valid = '0;
  logic [TSW-1:0]        m_ts;
  logic [TAGW-1:0]       m_tag;
  logic [PW-1:0]         m_port;
  logic                  m_valid;
  logic                  m_ready = 1'b1;
  logic [PORTS*DCW-1:0]  drop_count;
  logic [PORTS-1:0]      overflow;

  ptp_ts_collect #(
    .PORTS            (PORTS),
    .PTP_TS_WIDTH     (TSW),
    .PTP_TAG_WIDTH    (TAGW),
    .FIFO_DEPTH       (DEPTH),
    .DROP_COUNT_WIDTH (DCW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_ptp_ts       (s_ts),
    .s_axis_ptp_ts_tag   (s_tag),
    .s_axis_ptp_ts_valid (s_valid),
    .m_axis_ptp_ts       (m_ts),
    .m_axis_ptp_ts_tag   (m_tag),
    .m_axis_ptp_ts_port  (m_port),
    .m_axis_ptp_ts_valid (m_valid),
    .m_axis_ptp_ts_ready (m_ready),
    .drop_count          (drop_count),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov1_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    mq [PORTS][$];
  int               mdrop [PORTS];
  logic [PORTS-1:0] mov = '0;
  bit               mv = 1'b0;
  logic [TSW-1:0]   mts = '0;
  logic [TAGW-1:0]  mtag = '0;
  int               mport = 0;
  int               rr = 0;

  task automatic model_step();
    bit was_full [PORTS];
    bit got;
    int p;
    if (rst) begin
      for (int i = 0; i < PORTS; i++) begin
        mq[i].delete();
        mdrop[i] = 0;
      end
      mv = 1'b0; mts = '0; mtag = '0; mport = 0; rr = 0; mov = '0;
    end else begin
      for (int i = 0; i < PORTS; i++) was_full[i] = (mq[i].size() == DEPTH);
      if (!mv || m_ready) begin
        got = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
          p = (rr + k) % PORTS;
          if (!got && mq[p].size() != 0) begin
            got = 1'b1;
            {mts, mtag} = mq[p].pop_front();
            mport = p;
            rr = (p + 1) % PORTS;
          end
        end
        mv = got;
      end
      for (int i = 0; i < PORTS; i++) begin
        mov[i] = 1'b0;
        if (s_valid[i]) begin
          if (was_full[i]) begin
            mov[i] = 1'b1;
            if (mdrop[i] < DMAX) mdrop[i]++;
          end else begin
            mq[i].push_back({s_ts[i*TSW +: TSW], s_tag[i*TAGW +: TAGW]});
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < PORTS; i++) mdrop[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("m_valid", {127'b0, m_valid}, {127'b0, mv});
      if (mv) begin
        chk("m_ts", 128'(m_ts), 128'(mts));
        chk("m_tag", 128'(m_tag), 128'(mtag));
        chk("m_port", 128'(m_port), 128'(mport));
      end
      chk("overflow", 128'(overflow), 128'(mov));
      for (int i = 0; i < PORTS; i++)
        chk("drop_count", 128'(drop_count[i*DCW +: DCW]), 128'(mdrop[i]));
      if (overflow[1]) ov1_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic [TSW-1:0] ts, input logic [TAGW-1:0] tag);
    s_ts[p*TSW +: TSW]    = ts;
    s_tag[p*TAGW +: TAGW] = tag;
    s_valid[p]            = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
  endtask

  logic [TAGW-1:0] got_tag [20];
  int              n_got;
  int              seq [8];
  int              n_seq;

  initial begin
    // Reset state
    cyc(3);
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_ts", 128'(m_ts), 128'(0));
    chk("rst_tag", 128'(m_tag), 128'(0));
    chk("rst_port", 128'(m_port), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    rst = 1'b0;
    cyc(1);

    // 1. Single record, two-cycle latency, one-cycle valid
    drive(2, 96'h1234, 16'h00A5);
    cyc(1); s_valid = '0;
    chk("t1_cycle1_valid", 128'(m_valid), 128'(0));
    cyc(1);
    chk("t1_valid", 128'(m_valid), 128'(1));
    chk("t1_ts", 128'(m_ts), 128'h1234);
    chk("t1_tag", 128'(m_tag), 128'h00A5);
    chk("t1_port", 128'(m_port), 128'(2));
    cyc(1);
    chk("t1_valid_after", 128'(m_valid), 128'(0));

    // 2. All four ports at once, two bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < PORTS; i++) drive(i, TSW'(32'h10 + b*4 + i), TAGW'(b*4 + i));
      cyc(1); s_valid = '0;
      cyc(1);
      for (int k = 0; k < PORTS; k++) begin
        chk("t2_port", 128'(m_port), 128'(k));
        chk("t2_tag", 128'(m_tag), 128'(b*4 + k));
        cyc(1);
      end
      chk("t2_idle", 128'(m_valid), 128'(0));
    end

    // 3. Backpressure on port 1: 17 held, 18th dropped
    do_reset();
    m_ready = 1'b0;
    ov1_seen = 0;
    for (int k = 0; k < 18; k++) begin
      drive(1, TSW'(k), TAGW'(16'h100 + k));
      cyc(1);
    end
    s_valid = '0;
    cyc(2);
    chk("t3_drop1", 128'(drop_count[1*DCW +: DCW]), 128'(1));
    chk("t3_ovf_pulses", 128'(ov1_seen), 128'(1));
    m_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && n_got < 20) begin
        got_tag[n_got] = m_tag;
        n_got++;
      end
      cyc(1);
    end
    chk("t3_count", 128'(n_got), 128'(17));
    for (int j = 0; j < 17; j++) chk("t3_order", 128'(got_tag[j]), 128'(16'h100 + j));

    // 4. Saturating drop counter on port 0
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 37; k++) begin
      drive(0, TSW'(k), TAGW'(k));
      cyc(1);
    end
    s_valid = '0;
    cyc(2);
    chk("t4_sat", 128'(drop_count[0 +: DCW]), 128'(15));
    for (int k = 0; k < 3; k++) begin
      drive(0, TSW'(k), TAGW'(k));
      cyc(1);
    end
    s_valid = '0;
    cyc(2);
    chk("t4_sat_hold", 128'(drop_count[0 +: DCW]), 128'(15));
    m_ready = 1'b1;
    cyc(25);

    // 5. Fairness between ports 0 and 3
    do_reset();
    n_seq = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 12) begin
        drive(0, TSW'(c), TAGW'(16'h500 + c));
        drive(3, TSW'(c), TAGW'(16'h530 + c));
      end else begin
        s_valid = '0;
      end
      if (m_valid && n_seq < 8) begin
        seq[n_seq] = int'(m_port);
        n_seq++;
      end
      cyc(1);
    end
    chk("t5_count", 128'(n_seq), 128'(8));
    for (int j = 0; j < 8; j++) chk("t5_alt", 128'(seq[j]), 128'((j % 2 == 0) ? 0 : 3));
    chk("t5_nodrop", 128'(drop_count), 128'(0));

    // 6. Reset in the middle of a backlog
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(2, TSW'(k), TAGW'(16'h600 + k));
      cyc(1);
    end
    s_valid = '0;
    cyc(1);
    chk("t6_pre_drop", 128'(drop_count[2*DCW +: DCW]), 128'(3));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 128'(m_valid), 128'(0));
    chk("t6_async_drop", 128'(drop_count), 128'(0));
    chk("t6_async_ovf", 128'(overflow), 128'(0));
    cyc(2);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk("t6_no_stale", 128'(m_valid), 128'(0));
    end
    drive(1, 96'hABCD, 16'h0066);
    cyc(1); s_valid = '0;
    chk("t6_lat1", 128'(m_valid), 128'(0));
    cyc(1);
    chk("t6_valid", 128'(m_valid), 128'(1));
    chk("t6_tag", 128'(m_tag), 128'h0066);
    chk("t6_port", 128'(m_port), 128'(1));
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
